// File: rtl/axi_sts_read_arbiter.sv
// axi_sts_read_arbiter
// Shares one AXI4-Lite read-only status slave between two read masters.
// Round-robin arbitration, one transaction outstanding, registered response
// path, and an optional response timeout that turns a hung slave into SLVERR.
module axi_sts_read_arbiter #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic                      s0_axi_arvalid,
    output logic                      s0_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [1:0]                s0_axi_rresp,
    output logic                      s0_axi_rvalid,
    input  logic                      s0_axi_rready,

    input  logic [AXI_ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic                      s1_axi_arvalid,
    output logic                      s1_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [1:0]                s1_axi_rresp,
    output logic                      s1_axi_rvalid,
    input  logic                      s1_axi_rready,

    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    // Counter is wide enough to hold TIMEOUT_CYCLES-1; at least one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Per-master views gathered into packed arrays, index = master number.
    logic [1:0]                     arvalid;
    logic [1:0][AXI_ADDR_WIDTH-1:0] araddr;
    logic [1:0]                     rready;
    logic [1:0]                     arready;
    logic [1:0]                     rvalid;

    assign arvalid = {s1_axi_arvalid, s0_axi_arvalid};
    assign araddr  = {s1_axi_araddr,  s0_axi_araddr};
    assign rready  = {s1_axi_rready,  s0_axi_rready};

    logic [1:0]                state_q, state_d;
    logic                      grant_q, grant_d;
    logic                      last_q,  last_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [CNT_W-1:0]          cnt_q,   cnt_d;

    logic win;
    logic idle;

    assign idle = (state_q == ST_IDLE);

    // Round-robin pick: a lone requester wins, contention goes to the master
    // that was not granted last.
    always_comb begin
        if (arvalid == 2'b11) begin
            win = ~last_q;
        end else begin
            win = arvalid[1];
        end
    end

    // Per-master handshake outputs; arready only in IDLE, rvalid only to the
    // granted master in RESP.
    for (genvar p = 0; p < 2; p++) begin : g_port
        assign arready[p] = idle && arvalid[p] && (win == 1'(p));
        assign rvalid[p]  = (state_q == ST_RESP) && (grant_q == 1'(p));
    end

    assign s0_axi_arready = arready[0];
    assign s1_axi_arready = arready[1];
    assign s0_axi_rvalid  = rvalid[0];
    assign s1_axi_rvalid  = rvalid[1];

    // Response data is the latched beat, shared by both ports and qualified
    // only by rvalid.
    assign s0_axi_rdata = rdata_q;
    assign s0_axi_rresp = rresp_q;
    assign s1_axi_rdata = rdata_q;
    assign s1_axi_rresp = rresp_q;

    assign m_axi_araddr  = addr_q;
    assign m_axi_arvalid = (state_q == ST_ADDR);
    // Ready everywhere except RESP so a late beat after a timeout is drained
    // and dropped instead of stalling the slave.
    assign m_axi_rready  = (state_q != ST_RESP);

    // Next-state and datapath update for the single outstanding transaction.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|arvalid) begin
                    grant_d = win;
                    last_d  = win;
                    addr_d  = araddr[win];
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_axi_arready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    rresp_d = m_axi_rresp;
                    state_d = ST_RESP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rready[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; last resets to 1 so master 0 wins the first contention.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            rdata_q <= '0;
            rresp_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_sts_read_arbiter.sv
// Directed bench for axi_sts_read_arbiter: a cycle table for single reads and
// error pass-through, plus hand sequences for contention, back-pressure,
// timeout with a late beat, and reset mid-transaction.
module tb_axi_sts_read_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;

    logic [15:0] s0_axi_araddr = '0;
    logic        s0_axi_arvalid = 1'b0;
    logic        s0_axi_arready;
    logic [31:0] s0_axi_rdata;
    logic [1:0]  s0_axi_rresp;
    logic        s0_axi_rvalid;
    logic        s0_axi_rready = 1'b0;

    logic [15:0] s1_axi_araddr = '0;
    logic        s1_axi_arvalid = 1'b0;
    logic        s1_axi_arready;
    logic [31:0] s1_axi_rdata;
    logic [1:0]  s1_axi_rresp;
    logic        s1_axi_rvalid;
    logic        s1_axi_rready = 1'b0;

    logic [15:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b1;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    // Slave model controls
    logic        slv_fixed = 1'b1;
    logic [31:0] slv_data  = '0;
    logic [1:0]  slv_resp  = 2'b00;
    logic        slv_hang  = 1'b0;
    logic        late_go   = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    axi_sts_read_arbiter #(
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s0_axi_araddr (s0_axi_araddr),
        .s0_axi_arvalid(s0_axi_arvalid),
        .s0_axi_arready(s0_axi_arready),
        .s0_axi_rdata  (s0_axi_rdata),
        .s0_axi_rresp  (s0_axi_rresp),
        .s0_axi_rvalid (s0_axi_rvalid),
        .s0_axi_rready (s0_axi_rready),
        .s1_axi_araddr (s1_axi_araddr),
        .s1_axi_arvalid(s1_axi_arvalid),
        .s1_axi_arready(s1_axi_arready),
        .s1_axi_rdata  (s1_axi_rdata),
        .s1_axi_rresp  (s1_axi_rresp),
        .s1_axi_rvalid (s1_axi_rvalid),
        .s1_axi_rready (s1_axi_rready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    always #5 aclk = ~aclk;

    // Status slave: arready tied high, answers one cycle after AR unless hung.
    // Default data is 0xDA7A_<addr>; late_go injects a stray 0x12345678 beat.
    always @(posedge aclk) begin
        if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
        if (m_axi_arvalid && m_axi_arready && !slv_hang) begin
            m_axi_rvalid <= 1'b1;
            m_axi_rdata  <= slv_fixed ? slv_data : {16'hDA7A, m_axi_araddr};
            m_axi_rresp  <= slv_resp;
        end
        if (late_go) begin
            m_axi_rvalid <= 1'b1;
            m_axi_rdata  <= 32'h12345678;
            m_axi_rresp  <= 2'b00;
        end
    end

    typedef struct {
        logic        av0, av1, rr0, rr1;
        logic [15:0] a0, a1;
        logic [31:0] sdata;
        logic [1:0]  sresp;
        logic [89:0] exp;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(input logic av0, input logic [15:0] a0,
                                input logic av1, input logic [15:0] a1,
                                input logic rr0, input logic rr1,
                                input logic [31:0] sdata, input logic [1:0] sresp,
                                input logic ar0, input logic ar1,
                                input logic marv, input logic mrr,
                                input logic rv0, input logic rv1,
                                input logic [15:0] maddr,
                                input logic [31:0] rdata, input logic [1:0] rresp);
        vec_t v;
        v.av0 = av0; v.a0 = a0; v.av1 = av1; v.a1 = a1;
        v.rr0 = rr0; v.rr1 = rr1; v.sdata = sdata; v.sresp = sresp;
        v.exp = {ar0, ar1, marv, mrr, rv0, rv1, maddr, rdata, rresp, rdata, rresp};
        return v;
    endfunction

    function automatic logic [89:0] outs();
        return {s0_axi_arready, s1_axi_arready, m_axi_arvalid, m_axi_rready,
                s0_axi_rvalid, s1_axi_rvalid, m_axi_araddr,
                s0_axi_rdata, s0_axi_rresp, s1_axi_rdata, s1_axi_rresp};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Wait (bounded) for rvalid on one port; returns at the sampled cycle.
    task automatic wait_rv(input bit port, input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge aclk); #1;
            if (port ? s1_axi_rvalid : s0_axi_rvalid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit ar0_seen;
        int ng, nr, dt;

        // Two reads: s0 @0x0004 -> DEADBEEF/OKAY, then s1 @0x0008 -> CAFEF00D/2'b11.
        //             av0 a0     av1 a1    rr0 rr1 sdata         sresp ar0 ar1 marv mrr rv0 rv1 maddr  rdata         rresp
        tbl[0] = mk(1, 16'h4, 0, 16'h0, 0, 0, 32'hDEADBEEF, 2'b00, 1, 0, 0, 1, 0, 0, 16'h0, 32'h0,        2'b00);
        tbl[1] = mk(0, 16'h4, 0, 16'h0, 0, 0, 32'hDEADBEEF, 2'b00, 0, 0, 1, 1, 0, 0, 16'h4, 32'h0,        2'b00);
        tbl[2] = mk(0, 16'h4, 0, 16'h0, 0, 0, 32'hDEADBEEF, 2'b00, 0, 0, 0, 1, 0, 0, 16'h4, 32'h0,        2'b00);
        tbl[3] = mk(0, 16'h4, 0, 16'h0, 1, 0, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 1, 0, 16'h4, 32'hDEADBEEF, 2'b00);
        tbl[4] = mk(0, 16'h4, 0, 16'h0, 1, 0, 32'hDEADBEEF, 2'b00, 0, 0, 0, 1, 0, 0, 16'h4, 32'hDEADBEEF, 2'b00);
        tbl[5] = mk(0, 16'h4, 1, 16'h8, 0, 0, 32'hCAFEF00D, 2'b11, 0, 1, 0, 1, 0, 0, 16'h4, 32'hDEADBEEF, 2'b00);
        tbl[6] = mk(0, 16'h4, 0, 16'h8, 0, 0, 32'hCAFEF00D, 2'b11, 0, 0, 1, 1, 0, 0, 16'h8, 32'hDEADBEEF, 2'b00);
        tbl[7] = mk(0, 16'h4, 0, 16'h8, 0, 0, 32'hCAFEF00D, 2'b11, 0, 0, 0, 1, 0, 0, 16'h8, 32'hDEADBEEF, 2'b00);
        tbl[8] = mk(0, 16'h4, 0, 16'h8, 0, 1, 32'hCAFEF00D, 2'b11, 0, 0, 0, 0, 0, 1, 16'h8, 32'hCAFEF00D, 2'b11);
        tbl[9] = mk(0, 16'h4, 0, 16'h8, 0, 1, 32'hCAFEF00D, 2'b11, 0, 0, 0, 1, 0, 0, 16'h8, 32'hCAFEF00D, 2'b11);

        // Reset state
        repeat (3) @(negedge aclk);
        #1;
        check("reset_outputs", 128'(outs()), 128'({6'b000100, 16'h0, 32'h0, 2'b00, 32'h0, 2'b00}));
        @(negedge aclk);
        aresetn = 1'b1;

        // Table: cycle-by-cycle single reads, latency and error pass-through
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            s0_axi_arvalid = tbl[i].av0; s0_axi_araddr = tbl[i].a0;
            s1_axi_arvalid = tbl[i].av1; s1_axi_araddr = tbl[i].a1;
            s0_axi_rready  = tbl[i].rr0; s1_axi_rready = tbl[i].rr1;
            slv_data = tbl[i].sdata; slv_resp = tbl[i].sresp;
            #1;
            check($sformatf("table_row%0d", i), 128'(outs()), 128'(tbl[i].exp));
        end

        // Contention: both masters hold arvalid for 6 grants; expect 0,1,0,1,0,1
        slv_fixed = 1'b0; slv_resp = 2'b00;
        s0_axi_rready = 1'b1; s1_axi_rready = 1'b1;
        s0_axi_araddr = 16'h0000; s1_axi_araddr = 16'h0004;
        ng = 0; nr = 0;
        for (int cyc = 0; cyc < 200 && (ng < 6 || nr < 6); cyc++) begin
            @(negedge aclk);
            s0_axi_arvalid = (ng < 6);
            s1_axi_arvalid = (ng < 6);
            #1;
            if (s0_axi_arready && s1_axi_arready)
                check("cont_single_grant", 128'({s0_axi_arready, s1_axi_arready}), 128'(2'b10));
            if (s0_axi_arready || s1_axi_arready) begin
                check($sformatf("cont_grant%0d", ng), 128'(s1_axi_arready), 128'(ng % 2));
                ng++;
            end
            if (s0_axi_rvalid || s1_axi_rvalid) begin
                check($sformatf("cont_resp%0d", nr),
                      128'({s1_axi_rvalid, s0_axi_rvalid, s0_axi_rdata, s0_axi_rresp}),
                      128'({(nr % 2 == 1), (nr % 2 == 0),
                            (nr % 2 == 1) ? 32'hDA7A0004 : 32'hDA7A0000, 2'b00}));
                nr++;
            end
        end
        check("cont_done", 128'({ng, nr}), 128'({32'd6, 32'd6}));
        s0_axi_arvalid = 1'b0; s1_axi_arvalid = 1'b0;

        // Back-pressure: s1 stalls rready 10 cycles while s0 waits for a grant
        @(negedge aclk);
        s1_axi_araddr = 16'h000C; s1_axi_arvalid = 1'b1; s1_axi_rready = 1'b0;
        #1;
        check("bp_s1_grant", 128'(s1_axi_arready), 128'(1));
        @(negedge aclk);
        s1_axi_arvalid = 1'b0;
        s0_axi_araddr = 16'h0010; s0_axi_arvalid = 1'b1;
        #1;
        ar0_seen = s0_axi_arready;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge aclk); #1;
            ar0_seen |= s0_axi_arready;
            ok = s1_axi_rvalid;
        end
        check("bp_rvalid_arrives", 128'(ok), 128'(1));
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin @(negedge aclk); #1; end
            ar0_seen |= s0_axi_arready;
            check($sformatf("bp_stall%0d", i),
                  128'({s1_axi_rvalid, s1_axi_rdata, s0_axi_arready, s0_axi_rvalid}),
                  128'({1'b1, 32'hDA7A000C, 1'b0, 1'b0}));
        end
        @(negedge aclk);
        s1_axi_rready = 1'b1;
        #1;
        ar0_seen |= s0_axi_arready;
        check("bp_release", 128'({s1_axi_rvalid, s1_axi_rdata}), 128'({1'b1, 32'hDA7A000C}));
        check("bp_s0_held_off", 128'(ar0_seen), 128'(0));
        @(negedge aclk); #1;
        check("bp_s0_next", 128'(s0_axi_arready), 128'(1));
        @(negedge aclk);
        s0_axi_arvalid = 1'b0;
        wait_rv(1'b0, 10, ok);
        check("bp_s0_data", 128'({ok, s0_axi_rdata, s0_axi_rresp}), 128'({1'b1, 32'hDA7A0010, 2'b00}));

        // Timeout: hung slave -> SLVERR 9 cycles after the AR handshake cycle
        slv_hang = 1'b1;
        @(negedge aclk);
        s0_axi_araddr = 16'h0020; s0_axi_arvalid = 1'b1;
        #1;
        check("to_grant", 128'(s0_axi_arready), 128'(1));
        @(negedge aclk);
        s0_axi_arvalid = 1'b0;
        #1;
        check("to_ar_handshake", 128'({m_axi_arvalid, m_axi_araddr}), 128'({1'b1, 16'h0020}));
        dt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge aclk); #1;
            if (s0_axi_rvalid) begin dt = k; break; end
        end
        check("to_latency", 128'(dt), 128'(9));
        check("to_slverr", 128'({s0_axi_rdata, s0_axi_rresp, s1_axi_rvalid}),
              128'({32'h0, 2'b10, 1'b0}));
        @(negedge aclk);
        late_go = 1'b1;
        #1;
        check("late_rready", 128'({m_axi_rready, s0_axi_rvalid}), 128'({1'b1, 1'b0}));
        @(posedge aclk);
        #1 late_go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk); #1;
            check($sformatf("late_dropped%0d", i),
                  128'({s0_axi_rvalid, s1_axi_rvalid, s0_axi_rdata, s1_axi_rdata, m_axi_rready}),
                  128'({1'b0, 1'b0, 32'h0, 32'h0, 1'b1}));
        end
        check("late_absorbed", 128'(m_axi_rvalid), 128'(0));

        // Reset mid-transaction while in WAIT_R
        @(negedge aclk);
        s0_axi_araddr = 16'h0040; s0_axi_arvalid = 1'b1;
        #1;
        check("rst_grant", 128'(s0_axi_arready), 128'(1));
        @(negedge aclk);
        s0_axi_arvalid = 1'b0;
        @(negedge aclk); #1;
        check("rst_in_wait", 128'({m_axi_arvalid, m_axi_rready, s0_axi_rvalid}), 128'({1'b0, 1'b1, 1'b0}));
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check("rst_outputs", 128'(outs()), 128'({6'b000100, 16'h0, 32'h0, 2'b00, 32'h0, 2'b00}));
        slv_hang = 1'b0;
        @(negedge aclk);
        s0_axi_araddr = 16'h0044; s0_axi_arvalid = 1'b1;
        s1_axi_araddr = 16'h0048; s1_axi_arvalid = 1'b1;
        #1;
        check("rst_first_contention", 128'({s0_axi_arready, s1_axi_arready}), 128'(2'b10));
        @(negedge aclk);
        s0_axi_arvalid = 1'b0; s1_axi_arvalid = 1'b0;
        wait_rv(1'b0, 10, ok);
        check("rst_s0_data", 128'({ok, s0_axi_rdata}), 128'({1'b1, 32'hDA7A0044}));

        repeat (2) @(negedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
